bit_packer_mux: RTL and testbench
=================================

Name: bit_packer_mux

Overview:
- N-source bitstream packer: successor to the OR-combined single set_bit path.
- Selects one of N_SRC producers (header, Y/Cb/Cr component, alpha, ...) by index and appends each accepted write MSB-first into a byte-oriented output word stream.
- Adds parametrised output width, out_valid/out_ready backpressure, two-phase flush and a sticky source-switch error.
- Sits between the sequencer/producers and the frame memory writer; the sequencer consumes total_byte_size.

Parameters:
- N_SRC, 4, number of producer channels (2..8).
- VAL_W, 64, width of each producer's val bus; must be <= OUT_BYTES*8.
- OUT_BYTES, 8, output word width in bytes; OUT_W = OUT_BYTES*8.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- src_sel  in  clog2(N_SRC)  index of owning producer.
- enable  in  N_SRC  per-source write strobe.
- val  in  N_SRC*VAL_W  per-source value, source i at [i*VAL_W +: VAL_W]; only LSBs used.
- size_of_bit  in  N_SRC*7  per-source bit count 0..VAL_W.
- flush_bit  in  N_SRC  per-source flush request.
- in_ready  out  1  packer can accept a write/flush this cycle.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  downstream accepts word.
- out_data  out  OUT_W  packed bits, first bit at MSB.
- out_bytes  out  clog2(OUT_BYTES+1)  valid bytes in out_data, counted from MSB.
- total_byte_size  out  32  bytes handed off since reset.
- sel_err  out  1  sticky: src_sel changed while bits were pending.

Behaviour:
- Reset (reset_n=0 at a clock edge): fill=0, accumulator=0, state=RUN, out_valid=0, out_data=0, out_bytes=0, total_byte_size=0, sel_err=0. Applies mid-operation; pending bits are discarded.
- in_ready = !(out_valid && !out_ready) && state==RUN (combinational).
- Only the src_sel channel is sampled. enable/flush_bit on other channels are ignored with no side effect.
- Accepted write: enable[src_sel] && in_ready. Appends val[size-1:0] MSB-first after the fill existing bits; fill += size. size=0 is a no-op.
- Accumulator is 2*OUT_W bits.
- When fill >= OUT_W after an append, the top OUT_W bits load into out_data next cycle with out_valid=1 and out_bytes=OUT_BYTES; the residue shifts to the top and fill -= OUT_W.
- Latency is 1 cycle from the write edge to out_valid.
- Handshake:
  - out_valid stays high, with data stable, until out_valid && out_ready.
  - On handshake: total_byte_size += out_bytes; out_valid drops unless a new word loads the same cycle (back-to-back allowed).
- Flush: flush_bit[src_sel] && in_ready.
  - If enable is also set, the append happens first, then the flush.
  - Residue is zero-padded to the next byte boundary.
  - Post-append fill < OUT_W: emit a partial word next cycle, out_bytes = ceil(fill/8), low bytes zero.
  - Post-append fill >= OUT_W: emit the full word, enter state FLUSH2 (in_ready=0), emit the residue as a partial word once the full word handshakes, then return to RUN.
  - Flush with fill=0 emits nothing.
- FSM:
  - RUN -> FLUSH2 on a flush that leaves >= OUT_W bits.
  - FLUSH2 -> RUN once the residue word is loaded.
- sel_err: set when src_sel differs from the previous cycle while fill != 0. Cleared only by reset; no other effect.
- total_byte_size wraps modulo 2^32.

Test Plan:
- Write sel=0, val=0x5, size=3; then flush -> one word, out_data=0xA000_0000_0000_0000, out_bytes=1, total_byte_size=1.
- Write sel=1, val=0xFFFF_FFFF_FFFF_FFFF, size=64, out_ready=1 -> out_valid next cycle, out_data=all ones, out_bytes=8, total=8, fill=0.
- Write size=60 val=0, then size=8 val=0xFF with out_ready=0:
  - word 0x0000_0000_0000_000F appears and holds.
  - in_ready=0 while held.
  - Release -> total=8; residue 0xF0 pending with fill=4.
- From fill=60, simultaneous write size=16 val=0xABCD plus flush:
  - full word emitted, state FLUSH2, in_ready=0.
  - then out_data=0xBCD0_0000_0000_0000 with out_bytes=2; total=10.
- Write with sel=2, switch src_sel to 3 with fill=5 -> sel_err=1 and stays 1; writes on channel 2 while sel=3 are ignored.
- Reset asserted while out_valid=1 and fill=20 -> next cycle all outputs zero; a subsequent 8-bit write plus flush yields out_bytes=1, total=1.

Source files
------------

// File: rtl/bit_packer_mux.sv
// bit_packer_mux
// N-source MSB-first bitstream packer. One producer, chosen by src_sel, owns
// the packer; its writes are appended MSB-first into a 2*OUT_W accumulator.
// Complete OUT_W-bit words are handed to the frame memory writer through a
// registered output stage. A flush pads the residue to a byte boundary and
// emits it as a partial word.
//
// Ports:
//   clock, reset_n   system clock, synchronous active-low reset
//   src_sel          index of the producer that owns the packer
//   enable           per-source write strobe (only enable[src_sel] is used)
//   val              per-source value, source i at [i*VAL_W +: VAL_W]
//   size_of_bit      per-source bit count (7 bits each), 0..VAL_W
//   flush_bit        per-source flush request (only flush_bit[src_sel] is used)
//   in_ready         packer accepts a write/flush this cycle
//   out_valid/out_ready/out_data/out_bytes  output word stream
//   total_byte_size  bytes handed off since reset (wraps at 2^32)
//   sel_err          sticky: src_sel changed while bits were pending
//   dbg_state        FSM state (0 = RUN, 1 = FLUSH2)
//   dbg_fill         number of bits pending in the accumulator
//
// Handshakes: a word transfers on a clock edge where out_valid && out_ready.
// out_valid and out_data stay stable until that edge. An input write/flush is
// taken on an edge where in_ready is high together with enable/flush_bit of
// the selected source; in_ready does not depend on enable/flush_bit.
module bit_packer_mux #(
  parameter int N_SRC     = 4,
  parameter int VAL_W     = 64,
  parameter int OUT_BYTES = 8
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [$clog2(N_SRC)-1:0]              src_sel,
  input  logic [N_SRC-1:0]                      enable,
  input  logic [N_SRC*VAL_W-1:0]                val,
  input  logic [N_SRC*7-1:0]                    size_of_bit,
  input  logic [N_SRC-1:0]                      flush_bit,
  output logic                                  in_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [OUT_BYTES*8-1:0]                out_data,
  output logic [$clog2(OUT_BYTES+1)-1:0]        out_bytes,
  output logic [31:0]                           total_byte_size,
  output logic                                  sel_err,
  output logic                                  dbg_state,
  output logic [$clog2(2*OUT_BYTES*8+1)-1:0]    dbg_fill
);

  localparam int OUT_W  = OUT_BYTES * 8;
  localparam int ACC_W  = 2 * OUT_W;
  localparam int SEL_W  = $clog2(N_SRC);
  localparam int N_SLOT = 1 << SEL_W;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int OB_W   = $clog2(OUT_BYTES + 1);

  localparam logic [6:0]        VAL_W7   = 7'(VAL_W);
  localparam logic [FILL_W-1:0] OUT_W_F  = FILL_W'(OUT_W);
  localparam logic [OB_W-1:0]   FULL_OB  = OB_W'(OUT_BYTES);

  typedef enum logic {RUN = 1'b0, FLUSH2 = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 ov_d;
  logic [OUT_W-1:0]     od_d;
  logic [OB_W-1:0]      ob_d;
  logic [31:0]          tot_d;
  logic                 err_d;
  logic [SEL_W-1:0]     prev_sel;

  // Per-source buses unpacked into index-addressable slots; slots beyond
  // N_SRC (non power-of-two N_SRC) read as idle sources.
  logic [VAL_W-1:0]     val_arr  [N_SLOT];
  logic [6:0]           size_arr [N_SLOT];
  logic                 en_arr   [N_SLOT];
  logic                 fl_arr   [N_SLOT];

  for (genvar g = 0; g < N_SLOT; g++) begin : g_slot
    if (g < N_SRC) begin : g_src
      assign val_arr[g]  = val[g*VAL_W +: VAL_W];
      assign size_arr[g] = size_of_bit[g*7 +: 7];
      assign en_arr[g]   = enable[g];
      assign fl_arr[g]   = flush_bit[g];
    end else begin : g_pad
      assign val_arr[g]  = '0;
      assign size_arr[g] = '0;
      assign en_arr[g]   = 1'b0;
      assign fl_arr[g]   = 1'b0;
    end
  end

  logic                 out_free;
  logic                 wr, fl;
  logic [6:0]           size_c;
  logic [ACC_W-1:0]     wide, acc_a;
  logic [FILL_W-1:0]    fill_a;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    ov_d    = out_valid;
    od_d    = out_data;
    ob_d    = out_bytes;
    tot_d   = total_byte_size;
    err_d   = sel_err | ((src_sel != prev_sel) && (fill_q != '0));

    out_free = !out_valid || out_ready;
    in_ready = out_free && (state_q == RUN);
    wr       = in_ready && en_arr[src_sel];
    fl       = in_ready && fl_arr[src_sel];

    // Out-of-range sizes behave as a full VAL_W write.
    size_c = (size_arr[src_sel] > VAL_W7) ? VAL_W7 : size_arr[src_sel];

    // Place val at the accumulator MSB, then shift left by (VAL_W - size) so
    // bits above size fall off the top and val[size-1] lands at the MSB;
    // finally move it right past the bits already pending.
    wide   = {val_arr[src_sel], {(ACC_W-VAL_W){1'b0}}};
    acc_a  = acc_q;
    fill_a = fill_q;
    if (wr) begin
      acc_a  = acc_q | ((wide << (VAL_W7 - size_c)) >> fill_q);
      fill_a = fill_q + FILL_W'(size_c);
    end

    if (out_valid && out_ready) begin
      tot_d = total_byte_size + 32'(out_bytes);
      ov_d  = 1'b0;
    end

    if (state_q == RUN) begin
      acc_d  = acc_a;
      fill_d = fill_a;
      if (fill_a >= OUT_W_F) begin
        // Full word out; residue moves to the top. A flush here completes
        // in FLUSH2 after this word has been taken.
        ov_d   = 1'b1;
        od_d   = acc_a[ACC_W-1 -: OUT_W];
        ob_d   = FULL_OB;
        acc_d  = acc_a << OUT_W;
        fill_d = fill_a - OUT_W_F;
        if (fl) state_d = FLUSH2;
      end else if (fl && (fill_a != '0)) begin
        // Bits below fill are always zero, so the byte padding is free.
        ov_d   = 1'b1;
        od_d   = acc_a[ACC_W-1 -: OUT_W];
        ob_d   = OB_W'((fill_a + FILL_W'(7)) >> 3);
        acc_d  = '0;
        fill_d = '0;
      end
    end else begin
      if (out_free) begin
        if (fill_q != '0) begin
          ov_d = 1'b1;
          od_d = acc_q[ACC_W-1 -: OUT_W];
          ob_d = OB_W'((fill_q + FILL_W'(7)) >> 3);
        end
        acc_d   = '0;
        fill_d  = '0;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= RUN;
      acc_q           <= '0;
      fill_q          <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_bytes       <= '0;
      total_byte_size <= '0;
      sel_err         <= 1'b0;
      prev_sel        <= '0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      fill_q          <= fill_d;
      out_valid       <= ov_d;
      out_data        <= od_d;
      out_bytes       <= ob_d;
      total_byte_size <= tot_d;
      sel_err         <= err_d;
      prev_sel        <= src_sel;
    end
  end

  assign dbg_state = (state_q == FLUSH2);
  assign dbg_fill  = fill_q;

endmodule

// File: tb/tb_bit_packer_mux.sv
module tb_bit_packer_mux;

  localparam int N_SRC = 4;
  localparam int VAL_W = 64;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [1:0]    src_sel;
  logic [3:0]    enable;
  logic [255:0]  val;
  logic [27:0]   size_of_bit;
  logic [3:0]    flush_bit;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic [3:0]    out_bytes;
  logic [31:0]   total_byte_size;
  logic          sel_err;
  logic          dbg_state;
  logic [7:0]    dbg_fill;

  int n_assert = 0;
  int n_fail   = 0;

  bit_packer_mux #(.N_SRC(4), .VAL_W(64), .OUT_BYTES(8)) dut (
    .clock(clock), .reset_n(reset_n), .src_sel(src_sel), .enable(enable),
    .val(val), .size_of_bit(size_of_bit), .flush_bit(flush_bit),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_bytes(out_bytes),
    .total_byte_size(total_byte_size), .sel_err(sel_err),
    .dbg_state(dbg_state), .dbg_fill(dbg_fill)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver tasks
  task automatic clr_in();
    enable      = '0;
    flush_bit   = '0;
    val         = '0;
    size_of_bit = '0;
  endtask

  task automatic set_ch(input int ch, input logic [63:0] v, input logic [6:0] s,
                        input logic e, input logic f);
    val[ch*VAL_W +: VAL_W] = v;
    size_of_bit[ch*7 +: 7] = s;
    enable[ch]             = e;
    flush_bit[ch]          = f;
  endtask

  // checker
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    src_sel   = 2'd0;
    out_ready = 1'b1;
    clr_in();
    tick();
    tick();
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 64'h0);
    check("rst_bytes", out_bytes, 4'd0);
    check("rst_total", total_byte_size, 32'd0);
    check("rst_err", sel_err, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_fill", dbg_fill, 8'd0);
    reset_n = 1'b1;

    // 3-bit write then flush -> one partial byte
    set_ch(0, 64'h5, 7'd3, 1'b1, 1'b0);
    tick();
    check("w3_valid", out_valid, 1'b0);
    check("w3_fill", dbg_fill, 8'd3);
    clr_in();
    set_ch(0, 64'h0, 7'd0, 1'b0, 1'b1);
    tick();
    check("fl3_valid", out_valid, 1'b1);
    check("fl3_data", out_data, 64'hA000_0000_0000_0000);
    check("fl3_bytes", out_bytes, 4'd1);
    check("fl3_fill", dbg_fill, 8'd0);
    clr_in();
    tick();
    check("fl3_total", total_byte_size, 32'd1);
    check("fl3_drop", out_valid, 1'b0);

    // full 64-bit write on source 1 (switch with fill=0 raises no error)
    src_sel = 2'd1;
    set_ch(1, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1'b1, 1'b0);
    tick();
    check("w64_valid", out_valid, 1'b1);
    check("w64_data", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("w64_bytes", out_bytes, 4'd8);
    check("w64_fill", dbg_fill, 8'd0);
    clr_in();
    tick();
    check("w64_total", total_byte_size, 32'd9);
    check("w64_err", sel_err, 1'b0);

    // backpressure: 60 zeros + 0xFF, word held while out_ready=0
    set_ch(1, 64'h0, 7'd60, 1'b1, 1'b0);
    tick();
    check("bp_fill60", dbg_fill, 8'd60);
    out_ready = 1'b0;
    set_ch(1, 64'hFF, 7'd8, 1'b1, 1'b0);
    tick();
    check("bp_valid", out_valid, 1'b1);
    check("bp_data", out_data, 64'h0000_0000_0000_000F);
    check("bp_ready", in_ready, 1'b0);
    check("bp_fill", dbg_fill, 8'd4);
    // a write while held must be ignored
    set_ch(1, 64'h12, 7'd8, 1'b1, 1'b0);
    tick();
    check("bp_hold_data", out_data, 64'h0000_0000_0000_000F);
    check("bp_hold_valid", out_valid, 1'b1);
    check("bp_hold_fill", dbg_fill, 8'd4);
    check("bp_hold_total", total_byte_size, 32'd9);
    clr_in();
    out_ready = 1'b1;
    tick();
    check("bp_rel_total", total_byte_size, 32'd17);
    check("bp_rel_valid", out_valid, 1'b0);
    check("bp_rel_fill", dbg_fill, 8'd4);
    set_ch(1, 64'h0, 7'd0, 1'b0, 1'b1);
    tick();
    check("bp_fl_data", out_data, 64'hF000_0000_0000_0000);
    check("bp_fl_bytes", out_bytes, 4'd1);
    clr_in();
    tick();
    check("bp_fl_total", total_byte_size, 32'd18);

    // two-phase flush from fill=60 with a 16-bit write
    reset_n = 1'b0;
    src_sel = 2'd0;
    tick();
    reset_n = 1'b1;
    set_ch(0, 64'h0, 7'd60, 1'b1, 1'b0);
    tick();
    out_ready = 1'b0;
    set_ch(0, 64'hABCD, 7'd16, 1'b1, 1'b1);
    tick();
    check("f2_valid", out_valid, 1'b1);
    check("f2_data", out_data, 64'h0000_0000_0000_000A);
    check("f2_bytes", out_bytes, 4'd8);
    check("f2_state", dbg_state, 1'b1);
    check("f2_ready", in_ready, 1'b0);
    check("f2_fill", dbg_fill, 8'd12);
    clr_in();
    tick();
    check("f2_hold_state", dbg_state, 1'b1);
    check("f2_hold_data", out_data, 64'h0000_0000_0000_000A);
    out_ready = 1'b1;
    tick();
    check("f2_res_total", total_byte_size, 32'd8);
    check("f2_res_valid", out_valid, 1'b1);
    check("f2_res_data", out_data, 64'hBCD0_0000_0000_0000);
    check("f2_res_bytes", out_bytes, 4'd2);
    check("f2_res_state", dbg_state, 1'b0);
    tick();
    check("f2_total", total_byte_size, 32'd10);
    check("f2_drop", out_valid, 1'b0);
    check("f2_ready_back", in_ready, 1'b1);

    // sticky sel_err and foreign-channel isolation
    src_sel = 2'd2;
    set_ch(2, 64'h1F, 7'd5, 1'b1, 1'b0);
    tick();
    check("se_fill", dbg_fill, 8'd5);
    check("se_err0", sel_err, 1'b0);
    clr_in();
    src_sel = 2'd3;
    tick();
    check("se_err1", sel_err, 1'b1);
    set_ch(2, 64'hFF, 7'd8, 1'b1, 1'b1);
    tick();
    check("se_ign_fill", dbg_fill, 8'd5);
    check("se_ign_valid", out_valid, 1'b0);
    clr_in();
    src_sel = 2'd2;
    tick();
    tick();
    check("se_sticky", sel_err, 1'b1);
    src_sel = 2'd3;
    tick();
    set_ch(3, 64'h0, 7'd0, 1'b0, 1'b1);
    tick();
    check("se_fl_data", out_data, 64'hF800_0000_0000_0000);
    check("se_fl_bytes", out_bytes, 4'd1);
    clr_in();
    tick();
    check("se_fl_total", total_byte_size, 32'd11);
    check("se_still", sel_err, 1'b1);

    // reset while a word is held and 20 bits are pending
    src_sel = 2'd0;
    tick();
    set_ch(0, 64'h0, 7'd60, 1'b1, 1'b0);
    tick();
    out_ready = 1'b0;
    set_ch(0, 64'hFF_FFFF, 7'd24, 1'b1, 1'b0);
    tick();
    clr_in();
    check("mr_valid", out_valid, 1'b1);
    check("mr_data", out_data, 64'h0000_0000_0000_000F);
    check("mr_fill", dbg_fill, 8'd20);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mr_rst_valid", out_valid, 1'b0);
    check("mr_rst_data", out_data, 64'h0);
    check("mr_rst_bytes", out_bytes, 4'd0);
    check("mr_rst_total", total_byte_size, 32'd0);
    check("mr_rst_err", sel_err, 1'b0);
    check("mr_rst_fill", dbg_fill, 8'd0);
    check("mr_rst_ready", in_ready, 1'b1);
    set_ch(0, 64'h3C, 7'd8, 1'b1, 1'b1);
    tick();
    clr_in();
    check("mr_w_data", out_data, 64'h3C00_0000_0000_0000);
    check("mr_w_bytes", out_bytes, 4'd1);
    out_ready = 1'b1;
    tick();
    check("mr_w_total", total_byte_size, 32'd1);

    // size=0 write is a no-op
    set_ch(0, 64'hFFFF, 7'd0, 1'b1, 1'b0);
    tick();
    clr_in();
    check("z_fill", dbg_fill, 8'd0);
    check("z_valid", out_valid, 1'b0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
